// File: rtl/inst_fetch_queue_pkg.sv
// cpu_defs: shared reset vector, fetch FSM encoding and word transfer size
package cpu_defs;
    localparam logic [31:0] RESET_PC_DEF   = 32'hbfc00000;
    localparam logic [1:0]  INST_SIZE_WORD = 2'b10;
    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;
endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// fetch_fifo: synchronous ring FIFO with push/pop/clear and an occupancy count
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    // pointers carry an extra wrap bit so full and empty differ; clear empties in one cycle
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
    end
    // storage is not reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
    assign rdata = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: IF fetch engine, credit-limited pipelined inst_sram requests, in-order
// {pc,inst} buffer to ID, redirect flush with drop of old-stream responses.
// Optional macro INST_FETCH_PERF_EN adds perf_drop_cnt / perf_stall_cnt outputs.
module inst_fetch_queue
    import cpu_defs::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    input  logic        ex_flush,
    input  logic [31:0] ex_target,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
`ifdef INST_FETCH_PERF_EN
    output logic [31:0] perf_drop_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        fs_valid,
    input  logic        fs_ready,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);
    localparam int              CW  = $clog2(DEPTH);
    localparam logic [CW+1:0]   LIM = (CW+2)'(DEPTH);
    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   redir_pc;
    logic          redir_pend;
    logic [CW:0]   discard;
    logic [CW:0]   outstanding;
    logic [CW:0]   oq_cnt;
    logic [CW:0]   out_nxt;
    logic [CW:0]   oq_nxt;
    logic [31:0]   pcq_head;
    logic [63:0]   oq_head;
    logic [31:0]   target;
    logic          redirect;
    logic          issue;
    logic          keep;
    logic          pop_oq;
    logic          credit_nxt;
    logic          hold_req;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = INST_SIZE_WORD;
    assign inst_sram_wstrb = 4'b0;
    assign inst_sram_wdata = 32'b0;
    assign inst_sram_addr  = fetch_pc;
    assign fs_pc           = oq_head[63:32];
    assign fs_inst         = oq_head[31:0];

    // pc of every accepted request; popped by each response, old-stream ones included
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_q (
        .clk(clk), .resetn(resetn), .clear(1'b0), .push(issue), .pop(inst_sram_data_ok),
        .wdata(fetch_pc), .rdata(pcq_head), .count(outstanding)
    );
    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_out_q (
        .clk(clk), .resetn(resetn), .clear(redirect), .push(keep), .pop(pop_oq),
        .wdata({pcq_head, inst_sram_rdata}), .rdata(oq_head), .count(oq_cnt)
    );

    // cycle events and next-cycle occupancy used for the credit decision
    always_comb begin
        redirect   = ex_flush | br_redirect;
        target     = ex_flush ? ex_target : br_target;
        issue      = (state == S_REQ) & inst_sram_addr_ok;
        hold_req   = (state == S_REQ) & ~inst_sram_addr_ok;
        keep       = inst_sram_data_ok & (discard == '0) & ~redirect;
        pop_oq     = fs_valid & fs_ready;
        out_nxt    = outstanding + (CW+1)'(issue) - (CW+1)'(inst_sram_data_ok);
        oq_nxt     = redirect ? '0 : oq_cnt + (CW+1)'(keep) - (CW+1)'(pop_oq);
        credit_nxt = ({1'b0, out_nxt} + {1'b0, oq_nxt}) < LIM;
    end

    // fsm state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // an unaccepted request is held; otherwise request again whenever credit remains
    always_comb begin
        state_nxt = (hold_req | credit_nxt) ? S_REQ : S_IDLE;
    end

    // fsm outputs
    always_comb begin
        inst_sram_req = (state == S_REQ);
        fs_valid      = (oq_cnt != '0);
    end

    // fetch address, deferred redirect target and count of responses still to drop
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc   <= RESET_PC;
            redir_pc   <= '0;
            redir_pend <= 1'b0;
            discard    <= '0;
        end else begin
            if (redirect && hold_req) begin
                redir_pend <= 1'b1;
                redir_pc   <= target;
            end else if (redirect) begin
                fetch_pc   <= target;
                redir_pend <= 1'b0;
            end else if (issue) begin
                fetch_pc   <= redir_pend ? redir_pc : fetch_pc + 32'd4;
                redir_pend <= 1'b0;
            end
            discard <= redirect ? out_nxt
                     : discard + (CW+1)'(issue & redir_pend)
                               - (CW+1)'(inst_sram_data_ok & (discard != '0));
        end
    end

`ifdef INST_FETCH_PERF_EN
    // free-running wrap-around counters of dropped responses and starved ID cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_drop_cnt  <= perf_drop_cnt + 32'(inst_sram_data_ok & ((discard != '0) | redirect));
            perf_stall_cnt <= perf_stall_cnt + 32'(fs_ready & ~fs_valid);
        end
    end
`endif

    a_dok_without_req: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_sram_data_ok && outstanding == '0));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scenarios plus random traffic against a queue-based model
module tb_inst_fetch_queue;
    import cpu_defs::*;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_redirect = 1'b0;
    logic [31:0] br_target = '0;
    logic        ex_flush = 1'b0;
    logic [31:0] ex_target = '0;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        fs_ready = 1'b0;
    logic        inst_sram_req, inst_sram_wr, fs_valid;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, fs_pc, fs_inst;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_drop_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .br_redirect(br_redirect), .br_target(br_target),
        .ex_flush(ex_flush), .ex_target(ex_target),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
`ifdef INST_FETCH_PERF_EN
        .perf_drop_cnt(perf_drop_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .fs_valid(fs_valid), .fs_ready(fs_ready), .fs_pc(fs_pc), .fs_inst(fs_inst)
    );

    // model: each in-flight fetch carries its pc and whether it belongs to a dead stream
    typedef struct packed {
        logic [31:0] pc;
        logic        drop;
    } fl_t;
    fl_t         infl[$];
    logic [63:0] outq[$];
    logic [31:0] issued[$];
    logic [31:0] m_addr = RESET_PC_DEF;
    logic [31:0] p_tgt = '0;
    bit          m_req = 1'b0;
    bit          p_pend = 1'b0;
    int          m_drops = 0, m_stalls = 0, m_pops = 0, m_issues = 0;
    int          vectors = 0, miscompares = 0;

    function automatic logic [31:0] word_of(logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h3c5a96e1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          redir;
        bit          iss;
        logic [31:0] tgt;
        fl_t         e;
        if (!resetn) begin
            infl.delete();
            outq.delete();
            m_addr = RESET_PC_DEF;
            m_req = 1'b0;
            p_pend = 1'b0;
            p_tgt = '0;
            m_drops = 0;
            m_stalls = 0;
        end else begin
            redir = br_redirect | ex_flush;
            tgt = ex_flush ? ex_target : br_target;
            iss = m_req && inst_sram_addr_ok;
            if (fs_ready && outq.size() == 0) m_stalls++;
            if (fs_ready && outq.size() > 0) begin
                void'(outq.pop_front());
                m_pops++;
            end
            if (inst_sram_data_ok) begin
                e = infl.pop_front();
                if (e.drop || redir) m_drops++;
                else outq.push_back({e.pc, inst_sram_rdata});
            end
            if (redir) begin
                outq.delete();
                foreach (infl[i]) infl[i].drop = 1'b1;
            end
            if (iss) begin
                infl.push_back({m_addr, redir || p_pend});
                issued.push_back(m_addr);
                m_issues++;
            end
            if (redir && m_req && !inst_sram_addr_ok) begin
                p_pend = 1'b1;
                p_tgt = tgt;
            end else if (redir) begin
                m_addr = tgt;
                p_pend = 1'b0;
            end else if (iss) begin
                m_addr = p_pend ? p_tgt : m_addr + 32'd4;
                p_pend = 1'b0;
            end
            m_req = (m_req && !inst_sram_addr_ok) || (infl.size() + outq.size() < DEPTH);
        end
    endtask

    task automatic compare_all();
        chk("req", 32'(inst_sram_req), 32'(m_req));
        if (m_req) chk("addr", inst_sram_addr, m_addr);
        chk("fs_valid", 32'(fs_valid), 32'(outq.size() > 0));
        if (outq.size() > 0) begin
            chk("fs_pc", fs_pc, outq[0][63:32]);
            chk("fs_inst", fs_inst, outq[0][31:0]);
        end
        chk("wr_size_wstrb", {25'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb}, 32'h20);
        chk("wdata", inst_sram_wdata, 32'h0);
`ifdef INST_FETCH_PERF_EN
        chk("perf_drop", perf_drop_cnt, 32'(m_drops));
        chk("perf_stall", perf_stall_cnt, 32'(m_stalls));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_dok(bit en);
        inst_sram_data_ok = en && infl.size() > 0;
        inst_sram_rdata = inst_sram_data_ok ? word_of(infl[0].pc) : $urandom();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        fs_ready = 1'b0;
        br_redirect = 1'b0;
        ex_flush = 1'b0;
        repeat (2) tick();
        chk("reset_req", 32'(inst_sram_req), 32'h0);
        chk("reset_valid", 32'(fs_valid), 32'h0);
        resetn = 1'b1;
        issued.delete();
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!fs_valid && n < 30) begin
            set_dok(1'b1);
            tick();
            n++;
        end
        if (!fs_valid) begin
            miscompares++;
            $display("FAIL %s: fs_valid never rose, got 0 expected 1", name);
        end
    endtask

    initial begin
        int i0, d0, p0, n;
        // streaming fetch from reset vector, one word per cycle
        do_reset();
        fs_ready = 1'b1;
        inst_sram_addr_ok = 1'b1;
        repeat (20) begin set_dok(1'b1); tick(); end
        chk("t1_addr0", issued[0], 32'hbfc00000);
        chk("t1_addr1", issued[1], 32'hbfc00004);
        chk("t1_addr2", issued[2], 32'hbfc00008);
        p0 = m_pops;
        repeat (8) begin set_dok(1'b1); tick(); end
        chk("t1_rate", 32'(m_pops - p0), 32'd8);
        // back-pressure limits fetches to DEPTH
        do_reset();
        inst_sram_addr_ok = 1'b1;
        i0 = m_issues;
        repeat (12) begin set_dok(1'b1); tick(); end
        chk("t2_issued", 32'(m_issues - i0), 32'd4);
        chk("t2_req_low", 32'(inst_sram_req), 32'h0);
        fs_ready = 1'b1;
        set_dok(1'b1);
        tick();
        fs_ready = 1'b0;
        repeat (6) begin set_dok(1'b1); tick(); end
        chk("t2_one_more", 32'(m_issues - i0), 32'd5);
        // branch with three old fetches in flight
        do_reset();
        fs_ready = 1'b1;
        inst_sram_addr_ok = 1'b1;
        n = 0;
        while (infl.size() < 2 && n < 20) begin tick(); n++; end
        d0 = m_drops;
        br_redirect = 1'b1;
        br_target = 32'h80001000;
        tick();
        br_redirect = 1'b0;
        wait_valid("t3_wait");
        chk("t3_first_pc", fs_pc, 32'h80001000);
        chk("t3_drops", 32'(m_drops - d0), 32'd3);
`ifdef INST_FETCH_PERF_EN
        chk("t3_perf_drop", perf_drop_cnt, 32'd3);
`endif
        // redirect while a request is stalled
        do_reset();
        fs_ready = 1'b1;
        tick();
        chk("t4_req", 32'(inst_sram_req), 32'h1);
        br_redirect = 1'b1;
        br_target = 32'h80004000;
        tick();
        br_redirect = 1'b0;
        repeat (4) begin tick(); chk("t4_hold", inst_sram_addr, 32'hbfc00000); end
        d0 = m_drops;
        inst_sram_addr_ok = 1'b1;
        tick();
        chk("t4_next", inst_sram_addr, 32'h80004000);
        wait_valid("t4_wait");
        chk("t4_first_pc", fs_pc, 32'h80004000);
        chk("t4_drops", 32'(m_drops - d0), 32'd1);
        // exception and branch together with addr_ok and data_ok
        do_reset();
        fs_ready = 1'b1;
        inst_sram_addr_ok = 1'b1;
        repeat (4) begin set_dok(1'b1); tick(); end
        d0 = m_drops;
        set_dok(1'b1);
        ex_flush = 1'b1;
        ex_target = 32'hbfc00380;
        br_redirect = 1'b1;
        br_target = 32'h80002000;
        tick();
        ex_flush = 1'b0;
        br_redirect = 1'b0;
        chk("t5_addr", inst_sram_addr, 32'hbfc00380);
        wait_valid("t5_wait");
        chk("t5_first_pc", fs_pc, 32'hbfc00380);
        chk("t5_drops", 32'(m_drops - d0), 32'd2);
        // fetch address wraps past the top of memory
        do_reset();
        inst_sram_addr_ok = 1'b1;
        br_redirect = 1'b1;
        br_target = 32'hfffffffc;
        tick();
        br_redirect = 1'b0;
        chk("t6_addr", inst_sram_addr, 32'hfffffffc);
        tick();
        chk("t6_wrap", inst_sram_addr, 32'h00000000);
        // random traffic
        do_reset();
        repeat (4000) begin
            int r;
            resetn = $urandom_range(0, 999) != 0;
            inst_sram_addr_ok = $urandom_range(0, 3) != 0;
            fs_ready = $urandom_range(0, 3) != 0;
            set_dok($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 39);
            br_redirect = (r == 0) || (r == 2);
            ex_flush = (r == 1) || (r == 2);
            br_target = $urandom() & 32'hfffffffc;
            ex_target = $urandom() & 32'hfffffffc;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
